pmp_chk_seq: RTL and testbench

- Sequential PMP checker; uses the 16 pmpNcfg/pmpNaddr outputs of the machine memory-protection CSR block as its configuration source.
- Scans one entry per cycle in priority order (entry 0 first) and returns an allow/fault verdict for one physical access at a time.
- Sits between the LSU/IFU request path and the bus, for low-area cores where 16 parallel comparators are too costly.

---
 rtl/pmp_chk_seq.sv | 152 +++++++++++++++
 tb/tb_pmp_chk_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_chk_seq.sv
// Sequential PMP checker: walks the PMP entries one per cycle in priority order
// and returns an allow/fault verdict for a single physical access.
module pmp_chk_seq #(
  parameter int XLEN      = 32,
  parameter int PADDR_LEN = 34,
  parameter int ENTRIES   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [8*ENTRIES-1:0]    pmp_cfg,
  input  logic [XLEN*ENTRIES-1:0] pmp_addr,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [PADDR_LEN-1:0]    req_paddr,
  input  logic [1:0]              req_size,
  input  logic [1:0]              req_type,
  input  logic [1:0]              req_priv,
  input  logic                    abort,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_fault,
  output logic                    rsp_hit,
  output logic [3:0]              rsp_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_EXEC  = 2'd2;
  localparam logic [1:0] PRIV_M  = 2'd3;

  state_t            state;
  logic [3:0]        idx;
  logic [XLEN-1:0]   sa, ea;
  logic [1:0]        typ, priv;

  // Entries beyond ENTRIES read as OFF so the 4-bit index never selects garbage.
  logic [7:0]        cfg_arr  [16];
  logic [XLEN-1:0]   addr_arr [16];

  for (genvar g = 0; g < 16; g++) begin : g_unpack
    if (g < ENTRIES) begin : g_used
      assign cfg_arr[g]  = pmp_cfg[8*g +: 8];
      assign addr_arr[g] = pmp_addr[XLEN*g +: XLEN];
    end else begin : g_unused
      assign cfg_arr[g]  = '0;
      assign addr_arr[g] = '0;
    end
  end

  function automatic logic in_range(input logic [1:0] a, input logic [XLEN-1:0] wa,
                                    input logic [XLEN-1:0] top, input logic [XLEN-1:0] base);
    logic [XLEN-1:0] t;
    t = top ^ (top + 1'b1);
    case (a)
      A_TOR:   return (base <= wa) && (wa < top);
      A_NA4:   return wa == top;
      A_NAPOT: return (wa & ~t) == (top & ~t);
      default: return 1'b0;
    endcase
  endfunction

  logic [7:0]           cfg;
  logic [XLEN-1:0]      top, prev;
  logic                 sa_in, ea_in, full, partial, perm, allow, last;
  logic [PADDR_LEN-1:0] req_end;

  assign req_ready = (state == IDLE);
  assign cfg       = cfg_arr[idx];
  assign top       = addr_arr[idx];
  assign prev      = (idx == 4'd0) ? '0 : addr_arr[idx - 4'd1];
  assign sa_in     = in_range(cfg[4:3], sa, top, prev);
  assign ea_in     = in_range(cfg[4:3], ea, top, prev);
  assign full      = sa_in & ea_in;
  assign partial   = sa_in ^ ea_in;
  assign last      = (idx == 4'(ENTRIES - 1));
  assign req_end   = req_paddr + (PADDR_LEN'(1) << req_size) - PADDR_LEN'(1);

  // NOTE: every path through a combinational block assigns a default first,
  // otherwise synthesis infers a latch to hold the previous value.
  always_comb begin
    perm = cfg[0];
    case (typ)
      T_WRITE: perm = cfg[1];
      T_EXEC:  perm = cfg[2];
      default: perm = cfg[0];
    endcase
  end

  // The lock bit is what makes the permission bits bind M-mode too.
  assign allow = ((priv == PRIV_M) && !cfg[7]) || perm;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      sa        <= '0;
      ea        <= '0;
      typ       <= '0;
      priv      <= '0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sa    <= XLEN'(req_paddr[PADDR_LEN-1:2]);
            ea    <= XLEN'(req_end[PADDR_LEN-1:2]);
            typ   <= req_type;
            priv  <= req_priv;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
          end else if (full || partial) begin
            rsp_fault <= partial | ~allow;
            rsp_hit   <= 1'b1;
            rsp_idx   <= idx;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (last) begin
            rsp_fault <= (priv != PRIV_M);
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        RESP: begin
          if (abort || rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_chk_seq.sv
// Directed bench for pmp_chk_seq: the driver queues hand-computed verdicts and
// latencies, an independent monitor compares them as responses appear.
module tb_pmp_chk_seq;

  logic          clk = 1'b0;
  logic          rstn;
  logic [127:0]  pmp_cfg;
  logic [511:0]  pmp_addr;
  logic          req_valid, req_ready;
  logic [33:0]   req_paddr;
  logic [1:0]    req_size, req_type, req_priv;
  logic          abort;
  logic          rsp_valid, rsp_ready, rsp_fault, rsp_hit;
  logic [3:0]    rsp_idx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic       fault;
    logic       hit;
    logic [3:0] idx;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];

  pmp_chk_seq dut (
    .clk(clk), .rstn(rstn), .pmp_cfg(pmp_cfg), .pmp_addr(pmp_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
    .req_size(req_size), .req_type(req_type), .req_priv(req_priv),
    .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_fault(rsp_fault), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per rising rsp_valid.
  initial begin
    bit   prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && !prev_v) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_fault", rsp_fault, e.fault);
          check("rsp_hit",   rsp_hit,   e.hit);
          check("rsp_idx",   rsp_idx,   e.idx);
          check("latency",   64'(cyc - e.acc), 64'(e.lat));
        end
      end
      prev_v = (rsp_valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_cfg();
    pmp_cfg  = '0;
    pmp_addr = '0;
  endtask

  task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
    pmp_cfg[8*i +: 8]   = c;
    pmp_addr[32*i +: 32] = a;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) @(negedge clk);
    if (rsp_valid !== 1'b1) begin
      check("rsp_timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  task automatic wait_done();
    wait_valid();
    if (rsp_valid === 1'b1) @(negedge clk);
  endtask

  // Called at a negedge; the acceptance cycle is the one in which req_valid is raised.
  task automatic do_req(input logic [33:0] pa, input logic [1:0] sz, input logic [1:0] ty,
                        input logic [1:0] pv, input logic f, input logic h,
                        input logic [3:0] ix, input int lat, input bit done, input bit ab_idle);
    exp_t e;
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_paddr = pa;
    req_size  = sz;
    req_type  = ty;
    req_priv  = pv;
    abort     = ab_idle;
    e = '{fault: f, hit: h, idx: ix, lat: lat, acc: cyc};
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    abort     = 1'b0;
    if (done) wait_done();
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_paddr = '0; req_size = '0;
    req_type = '0; req_priv = '0; abort = 1'b0; rsp_ready = 1'b1;
    clear_cfg();
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_fault", rsp_fault, 1'b0);
    check("reset_rsp_hit",   rsp_hit,   1'b0);
    check("reset_rsp_idx",   rsp_idx,   4'd0);
    rstn = 1'b1;
    @(negedge clk);

    // NAPOT 0x8000_0000..0x8000_0FFF RW at entry 0
    set_entry(0, 8'h1B, 32'h2000_01FF);
    do_req(34'h0_8000_0010, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 4'd0, 2, 1, 0);
    do_req(34'h0_8000_0010, 2'd2, 2'd2, 2'd1, 1'b1, 1'b1, 4'd0, 2, 1, 0);
    do_req(34'h0_8000_0FFC, 2'd3, 2'd0, 2'd1, 1'b1, 1'b1, 4'd0, 2, 1, 0);
    // abort raised in IDLE must not block acceptance
    do_req(34'h0_8000_0010, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 4'd0, 2, 1, 1);

    // no permissions, unlocked: M allowed, S faults
    set_entry(0, 8'h18, 32'h2000_01FF);
    do_req(34'h0_8000_0010, 2'd2, 2'd1, 2'd3, 1'b0, 1'b1, 4'd0, 2, 1, 0);
    do_req(34'h0_8000_0010, 2'd2, 2'd1, 2'd1, 1'b1, 1'b1, 4'd0, 2, 1, 0);

    // TOR [0x8000_0000, 0x8000_1000) RX at entry 1
    clear_cfg();
    set_entry(0, 8'h00, 32'h2000_0000);
    set_entry(1, 8'h0D, 32'h2000_0400);
    do_req(34'h0_8000_0800, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'd1, 3, 1, 0);
    do_req(34'h0_8000_0800, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 4'd1, 3, 1, 0);
    do_req(34'h0_8000_1000, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 17, 1, 0);
    do_req(34'h0_8000_1000, 2'd2, 2'd0, 2'd3, 1'b0, 1'b0, 4'd0, 17, 1, 0);
    do_req(34'h0_7FFF_FFFC, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 17, 1, 0);

    // locked NA4 read-only at entry 3
    clear_cfg();
    set_entry(3, 8'h91, 32'h2000_0004);
    do_req(34'h0_8000_0010, 2'd2, 2'd1, 2'd3, 1'b1, 1'b1, 4'd3, 5, 1, 0);
    do_req(34'h0_8000_0010, 2'd2, 2'd0, 2'd3, 1'b0, 1'b1, 4'd3, 5, 1, 0);

    // all-ones NAPOT at the last entry, including an end address that wraps
    clear_cfg();
    set_entry(15, 8'h1F, 32'hFFFF_FFFF);
    do_req(34'h1_2345_6780, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 4'd15, 17, 1, 0);
    do_req(34'h3_FFFF_FFFC, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 4'd15, 17, 1, 0);

    // backpressure: verdict held for three cycles, then immediate re-acceptance
    clear_cfg();
    set_entry(0, 8'h1B, 32'h2000_01FF);
    rsp_ready = 1'b0;
    do_req(34'h0_8000_0010, 2'd2, 2'd2, 2'd1, 1'b1, 1'b1, 4'd0, 2, 0, 0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_fault", rsp_fault, 1'b1);
      check("bp_rsp_hit",   rsp_hit,   1'b1);
      check("bp_rsp_idx",   rsp_idx,   4'd0);
      check("bp_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_ready", req_ready, 1'b1);
    do_req(34'h0_8000_0020, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 4'd0, 2, 1, 0);

    // abort while scanning entry 5: no response may ever appear
    clear_cfg();
    req_valid = 1'b1; req_paddr = 34'h0_8000_0000; req_size = 2'd2;
    req_type = 2'd0; req_priv = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pre_valid", rsp_valid, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    repeat (20) @(negedge clk);

    // reset while a response is pending
    set_entry(3, 8'h91, 32'h2000_0004);
    rsp_ready = 1'b0;
    do_req(34'h0_8000_0010, 2'd2, 2'd1, 2'd3, 1'b1, 1'b1, 4'd3, 5, 0, 0);
    wait_valid();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", rsp_valid, 1'b0);
    check("rst_resp_ready", req_ready, 1'b1);
    check("rst_resp_fault", rsp_fault, 1'b0);
    check("rst_resp_hit",   rsp_hit,   1'b0);
    check("rst_resp_idx",   rsp_idx,   4'd0);
    rstn = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    do_req(34'h0_8000_0010, 2'd2, 2'd0, 2'd3, 1'b0, 1'b1, 4'd3, 5, 1, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
